board_renderer: RTL and testbench

Scans the 10×20 board RAM cell by cell and paints every cell as a CELL_PX×CELL_PX square into the VGA adapter's pixel write port. The game controller writes board state into `ram_board` and pulses `start` after each board update. This block owns the second read port of the board RAM and produces `x`/`y`/`colour`/`plot` for the 160×120, 6-bit-colour VGA adapter.

---
 rtl/tetris_pkg.sv | 30 +++
 rtl/cell_painter.sv | 47 ++++
 rtl/board_renderer.sv | 149 ++++++++++++++
 tb/tb_board_renderer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared constants, renderer state encoding and pixel record for the board renderer.
package tetris_pkg;
  localparam int BOARD_W  = 10;
  localparam int BOARD_H  = 20;
  localparam int CELL_PX  = 5;
  localparam int COLOUR_W = 6;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int ADDR_W   = 8;
  localparam int COL_W    = $clog2(BOARD_W);
  localparam int ROW_W    = $clog2(BOARD_H);
  localparam int PX_W     = $clog2(CELL_PX);

  localparam logic [COLOUR_W-1:0] GRID_COLOUR = 6'b010101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_PAINT,
    ST_DONE
  } render_state_e;

  typedef struct packed {
    logic                plot;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;
endpackage

// File: rtl/cell_painter.sv
// Pixel walker inside one cell: px inner, py outer. Offsets are next-cycle values
// so the parent can register the pixel that will be on the bus next cycle.
module cell_painter
  import tetris_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear_i,
  input  logic            adv_i,
  output logic [PX_W-1:0] off_x_o,
  output logic [PX_W-1:0] off_y_o,
  output logic            last_pixel_o
);
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(CELL_PX - 1);

  logic [PX_W-1:0] px_q, px_d, py_q, py_d;

  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (clear_i) begin
      px_d = '0;
      py_d = '0;
    end else if (adv_i) begin
      if (px_q == PX_LAST) begin
        px_d = '0;
        py_d = (py_q == PX_LAST) ? '0 : py_q + PX_W'(1);
      end else begin
        px_d = px_q + PX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      px_q <= '0;
      py_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
    end
  end

  assign off_x_o      = px_d;
  assign off_y_o      = py_d;
  assign last_pixel_o = (px_q == PX_LAST) && (py_q == PX_LAST);
endmodule

// File: rtl/board_renderer.sv
// Scans the board RAM and paints each cell as a CELL_PX square on the VGA write port.
// Optional build macro BOARD_RENDER_GRID_EN draws a grid line on empty cells.
module board_renderer
  import tetris_pkg::*;
#(
  parameter int ORIGIN_X = 55,
  parameter int ORIGIN_Y = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   ram_addr,
  input  logic [COLOUR_W-1:0] ram_rdata,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot
);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BOARD_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BOARD_H - 1);

  render_state_e       state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [X_W-1:0]      cell_x_q, cell_x_d;
  logic [Y_W-1:0]      cell_y_q, cell_y_d;
  logic [COLOUR_W-1:0] cell_colour_q, cell_colour_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                busy_q, busy_d, done_q, done_d;
  pixel_t              pix_q, pix_d;

  logic [PX_W-1:0]     off_x, off_y;
  logic                last_pixel;
  logic [COLOUR_W-1:0] colour_src;

  cell_painter u_painter (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (state_q == ST_LATCH),
    .adv_i        (state_q == ST_PAINT),
    .off_x_o      (off_x),
    .off_y_o      (off_y),
    .last_pixel_o (last_pixel)
  );

  // Cell bases and RAM address advance in raster order, so no multiply is needed.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    cell_x_d      = cell_x_q;
    cell_y_d      = cell_y_q;
    cell_colour_d = cell_colour_q;
    addr_d        = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_FETCH;
          col_d    = '0;
          row_d    = '0;
          cell_x_d = X_W'(ORIGIN_X);
          cell_y_d = Y_W'(ORIGIN_Y);
          addr_d   = '0;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        cell_colour_d = ram_rdata;
        state_d       = ST_PAINT;
      end
      ST_PAINT: begin
        if (last_pixel) begin
          if (col_q != COL_LAST) begin
            col_d    = col_q + COL_W'(1);
            cell_x_d = cell_x_q + X_W'(CELL_PX);
            addr_d   = addr_q + ADDR_W'(1);
            state_d  = ST_FETCH;
          end else if (row_q != ROW_LAST) begin
            col_d    = '0;
            row_d    = row_q + ROW_W'(1);
            cell_x_d = X_W'(ORIGIN_X);
            cell_y_d = cell_y_q + Y_W'(CELL_PX);
            addr_d   = addr_q + ADDR_W'(1);
            state_d  = ST_FETCH;
          end else begin
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output pixel is registered from next-state values so plot lines up with PAINT.
  always_comb begin
    pix_d      = pix_q;
    pix_d.plot = (state_d == ST_PAINT);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    colour_src = (state_q == ST_LATCH) ? ram_rdata : cell_colour_q;
    if (state_d == ST_PAINT) begin
      pix_d.x = cell_x_q + X_W'(off_x);
      pix_d.y = cell_y_q + Y_W'(off_y);
`ifdef BOARD_RENDER_GRID_EN
      pix_d.colour = ((colour_src == '0) && ((off_x == '0) || (off_y == '0)))
                   ? GRID_COLOUR : colour_src;
`else
      pix_d.colour = colour_src;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      col_q         <= '0;
      row_q         <= '0;
      cell_x_q      <= '0;
      cell_y_q      <= '0;
      cell_colour_q <= '0;
      addr_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pix_q         <= '0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      cell_x_q      <= cell_x_d;
      cell_y_q      <= cell_y_d;
      cell_colour_q <= cell_colour_d;
      addr_q        <= addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pix_q         <= pix_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ram_addr = addr_q;
  assign x        = pix_q.x;
  assign y        = pix_q.y;
  assign colour   = pix_q.colour;
  assign plot     = pix_q.plot;
endmodule

// File: tb/tb_board_renderer.sv
// Bench for board_renderer: synchronous board RAM model and a raster reference stream.
module tb_board_renderer;
`ifdef BOARD_RENDER_GRID_EN
  localparam bit GRID = 1'b1;
`else
  localparam bit GRID = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       busy, done, plot;
  logic [7:0] ram_addr, x;
  logic [6:0] y;
  logic [5:0] ram_rdata, colour;
  logic [5:0] mem [256];

  int errors = 0;
  int checks = 0;
  int n_plot, first_plot, last_plot, done_cyc, n_done, plots_after_rst, addr_probe;
  int gx[$], gy[$], gc[$];
  int ex[$], ey[$], ec[$];
  logic plot_hist [0:6000];
  logic busy_hist [0:6000];

  board_renderer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_rdata <= mem[ram_addr];

  task automatic fill_mem(input int mode);
    for (int i = 0; i < 256; i++) begin
      if (mode == 0) mem[i] = 6'h00;
      else mem[i] = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom_range(1, 63));
    end
  endtask

  // Reference: row-major cells, each a CELL x CELL square, px inner, py outer.
  task automatic build_expected();
    ex.delete(); ey.delete(); ec.delete();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        for (int py = 0; py < 5; py++)
          for (int px = 0; px < 5; px++) begin
            int col;
            col = int'(mem[r * 10 + c]);
            if (GRID && col == 0 && (px == 0 || py == 0)) col = 'h15;
            ex.push_back(55 + c * 5 + px);
            ey.push_back(10 + r * 5 + py);
            ec.push_back(col);
          end
  endtask

  function automatic int first_mismatch();
    int n;
    n = (gx.size() < ex.size()) ? gx.size() : ex.size();
    for (int i = 0; i < n; i++)
      if (gx[i] != ex[i] || gy[i] != ey[i] || gc[i] != ec[i]) return i;
    if (gx.size() != ex.size()) return n;
    return -1;
  endfunction

  // Cycle 0 is the cycle in which start is sampled; sampling at negedge k is cycle k.
  task automatic run_scan(input int hold, input int repulse, input int rst_at,
                          input int max_cyc, input int probe);
    n_plot = 0; first_plot = -1; last_plot = -1; done_cyc = -1; n_done = 0;
    plots_after_rst = 0; addr_probe = -1;
    gx.delete(); gy.delete(); gc.delete();
    for (int i = 0; i <= 6000; i++) begin plot_hist[i] = 1'b0; busy_hist[i] = 1'b0; end
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clk);
      start = (cyc < hold) || (cyc == repulse);
      if (rst_at > 0 && cyc == rst_at) begin
        reset_n = 1'b0;
        #1;
        checks++;
        if (plot !== 1'b0) begin errors++; $display("FAIL rst_plot_drop got=%b want=0", plot); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_drop got=%b want=0", busy); end
      end
      if (rst_at > 0 && cyc == rst_at + 5) reset_n = 1'b1;
      if (cyc == probe) addr_probe = int'(ram_addr);
      if (cyc <= 6000) begin plot_hist[cyc] = plot; busy_hist[cyc] = busy; end
      if (plot === 1'b1) begin
        n_plot++;
        if (first_plot < 0) first_plot = cyc;
        last_plot = cyc;
        gx.push_back(int'(x)); gy.push_back(int'(y)); gc.push_back(int'(colour));
        if (rst_at > 0 && cyc >= rst_at) plots_after_rst++;
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (hold <= 1 && n_done > 0 && cyc > done_cyc + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({x, y, colour} !== 21'd0) begin
      errors++; $display("FAIL reset_pixel got=%h want=0", {x, y, colour});
    end
    checks++;
    if ({plot, busy, done} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b want=000", {plot, busy, done});
    end
    checks++;
    if (ram_addr !== 8'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", ram_addr); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_all_zero();
    int ngrid, nzero, mm;
    fill_mem(0);
    build_expected();
    run_scan(1, -1, -1, 5600, -1);
    checks++;
    if (n_plot != 5000) begin errors++; $display("FAIL zero_plot_count got=%0d want=5000", n_plot); end
    checks++;
    if (first_plot != 3) begin errors++; $display("FAIL zero_first_plot got=%0d want=3", first_plot); end
    checks++;
    if (last_plot != 5400) begin errors++; $display("FAIL zero_last_plot got=%0d want=5400", last_plot); end
    checks++;
    if (done_cyc != 5401 || n_done != 1) begin
      errors++; $display("FAIL zero_done got=cyc%0d n%0d want=cyc5401 n1", done_cyc, n_done);
    end
    checks++;
    if (busy_hist[1] !== 1'b1 || busy_hist[5401] !== 1'b1 || busy_hist[5402] !== 1'b0) begin
      errors++; $display("FAIL zero_busy_window got=%b%b%b want=110",
                         busy_hist[1], busy_hist[5401], busy_hist[5402]);
    end
    checks++;
    if (gx.size() < 5000 || gx[0] != 55 || gy[0] != 10 || gx[4999] != 104 || gy[4999] != 109) begin
      errors++; $display("FAIL zero_corners got=size%0d want=(55,10)..(104,109)", gx.size());
    end
    ngrid = 0; nzero = 0;
    foreach (gc[i]) begin
      if (gc[i] == 'h15) ngrid++;
      if (gc[i] == 0) nzero++;
    end
    checks++;
    if (ngrid != (GRID ? 1800 : 0) || nzero != (GRID ? 3200 : 5000)) begin
      errors++; $display("FAIL zero_colour_split got=grid%0d zero%0d want=grid%0d zero%0d",
                         ngrid, nzero, GRID ? 1800 : 0, GRID ? 3200 : 5000);
    end
    mm = first_mismatch();
    checks++;
    if (mm != -1) begin errors++; $display("FAIL zero_stream got=mismatch@%0d want=none", mm); end
  endtask

  task automatic test_corner_cells();
    int nfirst, nlast, mm;
    fill_mem(0);
    mem[0] = 6'h30; mem[199] = 6'h0C;
    build_expected();
    run_scan(1, -1, -1, 5600, 5374);
    checks++;
    if (addr_probe != 199) begin errors++; $display("FAIL corner_last_fetch_addr got=%0d want=199", addr_probe); end
    nfirst = 0; nlast = 0;
    if (gx.size() == 5000) begin
      for (int i = 0; i < 25; i++) begin
        if (gc[i] == 'h30 && gx[i] == 55 + i % 5 && gy[i] == 10 + i / 5) nfirst++;
        if (gc[4975 + i] == 'h0C && gx[4975 + i] == 100 + i % 5 && gy[4975 + i] == 105 + i / 5) nlast++;
      end
    end
    checks++;
    if (nfirst != 25) begin errors++; $display("FAIL corner_first_cell got=%0d want=25", nfirst); end
    checks++;
    if (nlast != 25) begin errors++; $display("FAIL corner_last_cell got=%0d want=25", nlast); end
    checks++;
    if (gx.size() < 26 || gx[25] != 60 || gy[25] != 10 || gc[25] != (GRID ? 'h15 : 0)) begin
      errors++; $display("FAIL corner_pixel26 got=size%0d want=(60,10,%0h)", gx.size(), GRID ? 'h15 : 0);
    end
    mm = first_mismatch();
    checks++;
    if (mm != -1) begin errors++; $display("FAIL corner_stream got=mismatch@%0d want=none", mm); end
  endtask

  task automatic test_random();
    int mm;
    for (int k = 0; k < 2; k++) begin
      fill_mem(1);
      build_expected();
      run_scan(1, -1, -1, 5600, -1);
      mm = first_mismatch();
      checks++;
      if (mm != -1) begin errors++; $display("FAIL random_stream%0d got=mismatch@%0d want=none", k, mm); end
      checks++;
      if (done_cyc != 5401) begin errors++; $display("FAIL random_done%0d got=%0d want=5401", k, done_cyc); end
    end
  endtask

  task automatic test_restart_ignored();
    int mm;
    fill_mem(1);
    build_expected();
    run_scan(1, 1000, -1, 5600, -1);
    checks++;
    if (n_plot != 5000 || n_done != 1 || done_cyc != 5401) begin
      errors++; $display("FAIL restart_ignored got=plots%0d dones%0d cyc%0d want=5000 1 5401",
                         n_plot, n_done, done_cyc);
    end
    mm = first_mismatch();
    checks++;
    if (mm != -1) begin errors++; $display("FAIL restart_stream got=mismatch@%0d want=none", mm); end
  endtask

  task automatic test_reset_mid_scan();
    int mm;
    fill_mem(1);
    build_expected();
    // Cell 50 paints during cycles 1353..1377.
    run_scan(1, -1, 1360, 1500, -1);
    checks++;
    if (plots_after_rst != 0 || n_done != 0) begin
      errors++; $display("FAIL rst_aftermath got=plots%0d dones%0d want=0 0", plots_after_rst, n_done);
    end
    checks++;
    if (n_plot != 50 * 25 + 7 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_idle got=plots%0d busy%b want=1257 0", n_plot, busy);
    end
    run_scan(1, -1, -1, 5600, -1);
    mm = first_mismatch();
    checks++;
    if (mm != -1 || n_done != 1) begin
      errors++; $display("FAIL rst_rescan got=mismatch@%0d dones%0d want=none 1", mm, n_done);
    end
  endtask

  task automatic test_back_to_back();
    int waited;
    fill_mem(0);
    run_scan(5410, -1, -1, 5410, -1);
    checks++;
    if (n_done != 1 || busy_hist[5402] !== 1'b0 || busy_hist[5403] !== 1'b1) begin
      errors++; $display("FAIL b2b_restart got=dones%0d busy%b%b want=1 01",
                         n_done, busy_hist[5402], busy_hist[5403]);
    end
    checks++;
    if (plot_hist[5404] !== 1'b0 || plot_hist[5405] !== 1'b1) begin
      errors++; $display("FAIL b2b_first_plot got=%b%b want=01", plot_hist[5404], plot_hist[5405]);
    end
    waited = 0;
    while (busy === 1'b1 && waited < 6000) begin @(negedge clk); waited++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain got=busy%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_corner_cells();
    test_random();
    test_restart_ignored();
    test_reset_mid_scan();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
